// File: rtl/serial_sub_seq.sv
// serial_sub_seq
// Bit-serial WIDTH-bit subtractor sequencer. A parallel request (start) captures
// the operands, then a 1-bit full-subtractor cell is fed one bit pair per clock,
// LSB first. The borrow is kept in a flip-flop and each difference bit is shifted
// into the result register from the MSB side. After WIDTH steps the result,
// final borrow and signed overflow flag are published and done pulses once.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; results from the previous operation held
// RUN    | one cell step per clock, WIDTH steps in total (busy=1)
// DONE   | results just published; done=1 for this single cycle

// One-bit full subtractor: d = x - y - bin, with borrow out.
module serial_sub_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bo
);
    assign o_d  = i_x ^ i_y ^ i_bin;
    assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);
endmodule

module serial_sub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_res_next;
    logic             w_busy;
    logic             w_done;

    serial_sub_cell u_cell (
        .i_x   (r_sa[0]),
        .i_y   (r_sb[0]),
        .i_bin (r_borrow),
        .o_d   (w_d),
        .o_bo  (w_bo)
    );

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_step     = (r_state == S_RUN);
    assign w_last     = w_step && (r_cnt == LAST_CNT);
    // The final step's difference bit lands in the MSB of the published result.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; start is only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand shifters, borrow flip-flop, step counter and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_sa     <= a;
            r_sb     <= b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            // Operand MSBs are kept separately because r_sa/r_sb shift away.
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (w_step) begin
            r_res    <= w_res_next;
            r_borrow <= w_bo;
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Published results: updated only on the last step, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bo;
            // Signed overflow: operand signs differ and result sign differs from a.
            r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_sub_seq.sv
// Testbench for serial_sub_seq (WIDTH=8): vector table, hand-written corner
// sequences (ignored start, reset abort, result hold) and randomized
// back-to-back operations checked against an arithmetic reference model.
module tb_serial_sub_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t tbl[10];
    vec_t exp_q[$];

    serial_sub_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed readings.
    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t v;
        int   us;
        int   ss;
        us   = int'(x) - int'(y);
        ss   = int'($signed(x)) - int'($signed(y));
        v.a  = x;
        v.b  = y;
        v.d  = W'(us);
        v.bo = (us < 0);
        v.ov = (ss > 127) || (ss < -128);
        return v;
    endfunction

    // One operation with a start pulse; optionally re-pulses start (with other
    // operands) at RUN cycle index restart_at, which must be ignored.
    task automatic run_op(input vec_t v, input string nm, input int restart_at);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        a = v.a; b = v.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (cyc == restart_at) begin
                a = ~v.a; b = v.a ^ 8'h5A; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, "/done_seen"}, done, 1);
        chk({nm, "/busy_cycles"}, busy_cnt, W);
        chk({nm, "/busy_at_done"}, busy, 0);
        chk({nm, "/diff"}, diff, v.d);
        chk({nm, "/bout"}, bout, v.bo);
        chk({nm, "/ovf"}, ovf, v.ov);
        @(negedge clk);
        chk({nm, "/done_one_cycle"}, done, 0);
        chk({nm, "/diff_held"}, diff, v.d);
    endtask

    initial begin
        int dones;
        int cyc;
        int ops;
        int last_done;
        vec_t e;
        vec_t v;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
        tbl[9] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

        // Reset state.
        #12;
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/diff", diff, 0);
        chk("reset/bout", bout, 0);
        chk("reset/ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i), -1);
        end

        // start re-pulsed during RUN cycle 3 must be ignored, no second done.
        run_op(tbl[0], "ignore_start", 2);
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ignore_start/extra_done", dones, 0);
        chk("ignore_start/diff_kept", diff, tbl[0].d);

        // Result hold: a new accept does not clear the previous result.
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("hold/busy", busy, 1);
        chk("hold/diff_during_run", diff, tbl[0].d);
        chk("hold/bout_during_run", bout, tbl[0].bo);

        // Reset during RUN cycle 4 aborts the operation at once.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort/busy", busy, 0);
        chk("abort/done", done, 0);
        chk("abort/diff", diff, 0);
        chk("abort/bout", bout, 0);
        chk("abort/ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort/no_done", dones, 0);
        run_op(model(8'hA5, 8'h3C), "after_abort", -1);

        // Randomized back-to-back operations with start held high.
        @(negedge clk);
        v = model(W'($urandom), W'($urandom));
        exp_q.push_back(v);
        a = v.a; b = v.b; start = 1'b1;
        cyc = 0;
        ops = 0;
        last_done = -1;
        while (ops < 400 && cyc < 400 * (W + 2) + 50) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = exp_q.pop_front();
                chk($sformatf("rand%0d/diff", ops), diff, e.d);
                chk($sformatf("rand%0d/bout", ops), bout, e.bo);
                chk($sformatf("rand%0d/ovf", ops), ovf, e.ov);
                if (last_done >= 0) begin
                    chk($sformatf("rand%0d/interval", ops), cyc - last_done, W + 2);
                end
                last_done = cyc;
                ops++;
                if (ops < 400) begin
                    case ($urandom_range(0, 7))
                        0: v = model(8'h80, W'($urandom));
                        1: v = model(W'($urandom), 8'h7F);
                        2: v = model(8'h00, W'($urandom));
                        default: v = model(W'($urandom), W'($urandom));
                    endcase
                    exp_q.push_back(v);
                    a = v.a; b = v.b;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("rand/op_count", ops, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
